// File: rtl/mux_arb_pkg.sv
// -----------------------------------------------------------------------------
// mux_arb_pkg
// Shared types and helpers for the 4:1 mux round-robin arbiter.
//   state_e        : arbiter state (IDLE, GRANT)
//   NUM_REQ        : number of requesters sharing the mux path
//   idx_t          : 2-bit requester / mux-input index
//   idx_to_onehot  : index -> one-hot grant vector
// -----------------------------------------------------------------------------
package mux_arb_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  typedef logic [1:0] idx_t;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input idx_t idx);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// -----------------------------------------------------------------------------
// rr_pick4
// Combinational round-robin picker: returns the first set request bit at or
// after the pointer, scanning upward modulo 4.
// Ports:
//   req_i   [3:0] request vector
//   ptr_i   [1:0] scan start position
//   idx_o   [1:0] winning index (equals ptr_i when nothing is found)
//   found_o       high when any request bit is set
// -----------------------------------------------------------------------------
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  idx_t               ptr_i,
  output idx_t               idx_o,
  output logic               found_o
);

  idx_t cand;

  // Scan from the farthest offset back to the pointer so the nearest set bit
  // is the last assignment and therefore wins.
  always_comb begin
    idx_o   = ptr_i;
    found_o = 1'b0;
    cand    = ptr_i;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr_i + 2'(k);
      if (req_i[cand]) begin
        idx_o   = cand;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter
// Round-robin arbiter driving the select pins of a 4:1 input mux. One owner is
// granted at a time; on release the next requester is granted on the same
// edge, so there is never a gap while a request is pending.
// Optional hold-limit timeout: define MUX_RR_ARBITER_TIMEOUT_EN.
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   req   [3:0] level requests (bit i = mux input i+1)
//   done  [3:0] release pulse; only the current owner's bit is honoured
//   gnt   [3:0] one-hot registered grant
//   select_0    mux select MSB (registered)
//   select_1    mux select LSB (registered)
//   busy        high while a grant is active
//   timeout     one-cycle pulse when a grant is revoked by the hold limit
//   timeout_id  [1:0] index of the revoked owner, valid with timeout
// -----------------------------------------------------------------------------
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] gnt,
  output logic               select_0,
  output logic               select_1,
  output logic               busy,
  output logic               timeout,
  output logic [1:0]         timeout_id
);

  state_e             state_q, state_d;
  idx_t               ptr_q, ptr_d;
  idx_t               owner_q, owner_d;   // doubles as the select value
  logic [NUM_REQ-1:0] gnt_q, gnt_d;

  logic owner_release;
  logic limit_hit;
  logic new_grant;
  idx_t pick_ptr;
  idx_t pick_idx;
  logic pick_found;

  // One picker serves both decisions: from IDLE it scans from the stored
  // pointer, on release it scans from owner+1, which leaves the old owner as
  // the last candidate (re-granted only when it alone still requests).
  assign pick_ptr = (state_q == GRANT) ? idx_t'(owner_q + 2'd1) : ptr_q;

  rr_pick4 u_pick (
    .req_i   (req),
    .ptr_i   (pick_ptr),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  assign owner_release = (state_q == GRANT) && (done[owner_q] || !req[owner_q]);

`ifdef MUX_RR_ARBITER_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  idx_t             tid_q, tid_d;

  assign limit_hit = (state_q == GRANT) && (cnt_q == CNT_W'(MAX_HOLD - 1));
`else
  logic unused_cfg;
  assign unused_cfg = (MAX_HOLD > CNT_W);
  assign limit_hit  = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    gnt_d     = gnt_q;
    new_grant = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d   = GRANT;
          owner_d   = pick_idx;
          gnt_d     = idx_to_onehot(pick_idx);
          new_grant = 1'b1;
        end
      end
      GRANT: begin
        if (owner_release || limit_hit) begin
          ptr_d = idx_t'(owner_q + 2'd1);
          if (pick_found) begin
            owner_d   = pick_idx;
            gnt_d     = idx_to_onehot(pick_idx);
            new_grant = 1'b1;
          end else begin
            // Owner index is kept so the select lines hold in IDLE.
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: ;
    endcase
  end

`ifdef MUX_RR_ARBITER_TIMEOUT_EN
  always_comb begin
    // A normal release on the limit cycle takes precedence over the timeout.
    timeout_d = limit_hit && !owner_release;
    tid_d     = timeout_d ? owner_q : tid_q;
    if (new_grant) begin
      cnt_d = '0;
    end else if (state_q == GRANT) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      tid_q     <= '0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      tid_q     <= tid_d;
    end
  end

  assign timeout    = timeout_q;
  assign timeout_id = tid_q;
`else
  logic unused_grant_flag;
  assign unused_grant_flag = new_grant;
  assign timeout    = 1'b0;
  assign timeout_id = 2'b00;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt      = gnt_q;
  assign select_0 = owner_q[1];
  assign select_1 = owner_q[0];
  assign busy     = (state_q == GRANT);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_arbiter
// Self-checking bench for mux_rr_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// behavioural model. Honours MUX_RR_ARBITER_TIMEOUT_EN (MAX_HOLD = 4).
// -----------------------------------------------------------------------------
module tb_mux_rr_arbiter;

  localparam int MAX_HOLD = 4;
`ifdef MUX_RR_ARBITER_TIMEOUT_EN
  localparam bit TO_BUILD = 1'b1;
`else
  localparam bit TO_BUILD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] done = 4'b0000;
  logic [3:0] gnt;
  logic       select_0, select_1, busy, timeout;
  logic [1:0] timeout_id;

  int n_tests = 0;
  int n_fail  = 0;

  mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .done       (done),
    .gnt        (gnt),
    .select_0   (select_0),
    .select_1   (select_1),
    .busy       (busy),
    .timeout    (timeout),
    .timeout_id (timeout_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_owner = -1;   // -1 means no owner
  int m_ptr   = 0;
  int m_sel   = 0;
  int m_cyc   = 0;    // grant cycles completed by the current owner
  bit m_tout  = 1'b0;
  int m_tid   = 0;

  function automatic int first_from(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int w;
    bit rel_n;
    bit lim;
    logic [3:0] others;
    if (!rst_n) begin
      m_owner = -1; m_ptr = 0; m_sel = 0; m_cyc = 0; m_tout = 1'b0; m_tid = 0;
    end else begin
      m_tout = 1'b0;
      if (m_owner < 0) begin
        w = first_from(req, m_ptr);
        if (w >= 0) begin m_owner = w; m_sel = w; m_cyc = 1; end
      end else begin
        rel_n = done[m_owner] || !req[m_owner];
        lim   = TO_BUILD && (m_cyc == MAX_HOLD);
        if (rel_n || lim) begin
          if (!rel_n) begin m_tout = 1'b1; m_tid = m_owner; end
          m_ptr  = (m_owner + 1) % 4;
          others = req & ~(4'b0001 << m_owner);
          if (others != 4'b0000)  w = first_from(others, m_ptr);
          else if (req[m_owner])  w = m_owner;
          else                    w = -1;
          if (w >= 0) begin m_owner = w; m_sel = w; m_cyc = 1; end
          else m_owner = -1;
        end else begin
          m_cyc++;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [3:0] exp_gnt;
    exp_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    chk("gnt", 32'(gnt), 32'(exp_gnt));
    chk("select", 32'({select_0, select_1}), 32'(m_sel));
    chk("busy", 32'(busy), 32'(m_owner >= 0));
    chk("timeout", 32'(timeout), 32'(m_tout));
    if (m_tout) chk("timeout_id", 32'(timeout_id), 32'(m_tid));
    chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 4'b0000;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] rot_exp [5];
    int         tpulses;
    int         tfirst;
    bit         gnt_stuck_ok;

    rot_exp[0] = 4'b0001; rot_exp[1] = 4'b0010; rot_exp[2] = 4'b0100;
    rot_exp[3] = 4'b1000; rot_exp[4] = 4'b0001;

    // Reset values
    tick();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_sel", 32'({select_0, select_1}), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_timeout", 32'({timeout, timeout_id}), 32'h0);
    rst_n = 1'b1;
    tick();

    // Single request 0100
    req = 4'b0100;
    tick();
    chk("req0100_gnt", 32'(gnt), 32'h4);
    chk("req0100_sel", 32'({select_0, select_1}), 32'h2);
    chk("req0100_busy", 32'(busy), 32'h1);
    req = 4'b0000;
    tick();
    chk("drop_gnt", 32'(gnt), 32'h0);
    chk("drop_sel_hold", 32'({select_0, select_1}), 32'h2);

    // Full rotation, each owner releases on its second grant cycle
    do_reset();
    req = 4'b1111;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rot%0d_c1", i), 32'(gnt), 32'(rot_exp[i]));
      tick();
      chk($sformatf("rot%0d_c2", i), 32'(gnt), 32'(rot_exp[i]));
      done = rot_exp[i];
      tick();
      done = 4'b0000;
    end

    // Handoff 1 -> 3
    do_reset();
    req = 4'b0010;
    tick();
    req = 4'b1010;
    tick();
    chk("hand_before", 32'(gnt), 32'h2);
    chk("hand_sel_before", 32'({select_0, select_1}), 32'h1);
    done = 4'b0010;
    tick();
    done = 4'b0000;
    chk("hand_after", 32'(gnt), 32'h8);
    chk("hand_sel_after", 32'({select_0, select_1}), 32'h3);

    // Reset mid-grant
    do_reset();
    req = 4'b0100;
    tick();
    chk("midrst_pre", 32'(gnt), 32'h4);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_gnt", 32'(gnt), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_sel", 32'({select_0, select_1}), 32'h0);
    req = 4'b0101;
    tick();
    rst_n = 1'b1;
    tick();
    chk("postrst_gnt", 32'(gnt), 32'h1);

    // Hold limit
    do_reset();
    req = 4'b0001;
    tpulses = 0;
    tfirst  = -1;
    gnt_stuck_ok = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      tick();
      if (timeout) begin
        tpulses++;
        if (tfirst < 0) tfirst = t;
        chk("to_id", 32'(timeout_id), 32'h0);
      end
      if (gnt != 4'b0001) gnt_stuck_ok = 1'b0;
    end
    if (TO_BUILD) begin
      chk("to_pulses", 32'(tpulses), 32'd1);
      chk("to_first_edge", 32'(tfirst), 32'd5);
    end else begin
      chk("noto_pulses", 32'(tpulses), 32'd0);
      chk("noto_gnt_held", 32'(gnt_stuck_ok), 32'd1);
    end
    req = 4'b0000;
    tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 3) == 0) req = 4'($urandom);
        done = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0000;
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
